// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder datapath.
// Imported by the serial_adder top.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell.
// Leaf of the arithmetic datapath.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// Full adder cell built from two half adders.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (sum),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock,
// valid/ready on both operand and result sides.
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ov_q, ov_d;
  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // new bit enters at the MSB so the LSB lands at bit 0 last
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = fa_s;
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        carry_d        = fa_c;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          ov_d    = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Table vectors, hand sequences and random ops against an arithmetic model.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic       cin8, cout8, busy8;
  logic [7:0] a8, b8, sum8;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic       cin1, cout1, busy1;
  logic [0:0] a1, b1, sum1;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .busy      (busy8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         hold;
    logic [7:0] s;
    logic       c;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[8:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_,
                     input logic tc, input int hold,
                     output logic [7:0] rs, output logic rc,
                     output int lat);
    int n;
    logic [7:0] s0;
    logic c0;
    n = 0;
    while (!in_ready8 && n < 50) begin tick(); n++; end
    if (n >= 50) chk("wait_in_ready8", 0, 1);
    a8 = ta; b8 = tb_; cin8 = tc;
    in_valid8 = 1'b1;
    out_ready8 = (hold == 0);
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin tick(); lat++; end
    if (lat >= 50) chk("wait_out_valid8", 0, 1);
    rs = sum8; rc = cout8;
    s0 = sum8; c0 = cout8;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", out_valid8, 1);
      chk("bp_sum", sum8, s0);
      chk("bp_cout", cout8, c0);
      chk("bp_in_ready", in_ready8, 0);
    end
    out_ready8 = 1'b1;
    tick();
    chk("back_idle_in_ready", in_ready8, 1);
    chk("back_idle_out_valid", out_valid8, 0);
  endtask

  task automatic op1(input logic ta, input logic tb_, input logic tc,
                     output logic rs, output logic rc, output int lat);
    a1[0] = ta; b1[0] = tb_; cin1 = tc;
    in_valid1 = 1'b1;
    out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin tick(); lat++; end
    if (lat >= 20) chk("wait_out_valid1", 0, 1);
    rs = sum1[0]; rc = cout1;
    tick();
  endtask

  initial begin
    vec_t tbl[4];
    logic [7:0] rs;
    logic rc, r1s, r1c;
    int lat, n;
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic rcin;

    tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, hold: 0, s: 8'h10, c: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, hold: 0, s: 8'h00, c: 1'b1};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, hold: 0, s: 8'hFF, c: 1'b1};
    tbl[3] = '{a: 8'h3C, b: 8'h55, cin: 1'b0, hold: 5, s: 8'h91, c: 1'b0};

    rst_n = 1'b0;
    in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    #23;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].hold, rs, rc, lat);
      chk($sformatf("tbl%0d_sum", i), rs, tbl[i].s);
      chk($sformatf("tbl%0d_cout", i), rc, tbl[i].c);
      chk($sformatf("tbl%0d_lat", i), lat, 8);
    end

    // operands offered during RUN must be ignored until IDLE
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    a8 = 8'hAA; b8 = 8'h11;
    n = 0;
    while (!out_valid8 && n < 50) begin tick(); n++; end
    chk("holdoff_lat", n, 8);
    chk("holdoff_sum1", sum8, 8'h46);
    chk("holdoff_cout1", cout8, 0);
    tick();
    chk("holdoff_idle", in_ready8, 1);
    tick();
    chk("holdoff_accept2", busy8, 1);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin tick(); n++; end
    chk("holdoff_lat2", n, 8);
    chk("holdoff_sum2", sum8, 8'hBB);
    chk("holdoff_cout2", cout8, 0);
    tick();

    // reset mid-run
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_in_ready", in_ready8, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid8) n++;
    end
    chk("midrst_no_result", n, 0);
    op8(8'h01, 8'h02, 1'b0, 0, rs, rc, lat);
    chk("postrst_sum", rs, 8'h03);
    chk("postrst_cout", rc, 0);

    // exhaustive WIDTH=1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0], r1s, r1c, lat);
      exp = model({7'd0, v[2]}, {7'd0, v[1]}, v[0]);
      chk($sformatf("w1_%0d", i), {r1c, r1s}, exp[1:0]);
      chk($sformatf("w1_lat%0d", i), lat, 1);
    end

    // random ops with random backpressure
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rcin = 1'($urandom);
      op8(ra, rb, rcin, int'($urandom_range(0, 2)), rs, rc, lat);
      exp = model(ra, rb, rcin);
      chk($sformatf("rnd%0d_sum", i), rs, exp[7:0]);
      chk($sformatf("rnd%0d_cout", i), rc, exp[8]);
      chk($sformatf("rnd%0d_lat", i), lat, 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, through a full_adder cell built from two half_adder instances, with a registered carry.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits downstream of the half_adder cells: it is the sequential consumer of their sum/carry outputs in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  a + b + cin, low WIDTH bits.
- cout  output  1  carry-out of the full addition.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low; assertion takes effect immediately, deassertion is sampled on clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, internal shift registers/carry/counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift registers, carry_r<=cin, cnt<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: bit = a_sr[0]^b_sr[0]^carry_r (full_adder output); carry_r <= full_adder carry.
  - sum_sr shifts right with bit inserted at MSB; a_sr and b_sr shift right; cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge, go to DONE.
- DONE:
  - out_valid=1; sum=sum_sr; cout=carry_r.
  - Both held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid<=0.
- Latency: accept at edge k -> out_valid high after edge k+WIDTH. Throughput: one result per WIDTH+2 cycles minimum.
- Counter width: $clog2(WIDTH+1) bits. WIDTH=1 gives exactly one RUN cycle.
- Arithmetic: sum is modulo 2^WIDTH; {cout,sum} == a+b+cin exactly.
- in_valid during RUN/DONE is ignored; operands are not captured, and upstream must hold them until in_ready.
- out_ready while not in DONE has no effect.
- No overlap: in_ready stays 0 in DONE, even on the handshake cycle.
- Reset mid-operation (RUN or DONE): abort immediately to reset values; no out_valid is produced for the aborted operation.
- Outputs are registered; no combinational path from in_valid/out_ready to any output.

Decomposition:
- Shared package serial_add_pkg:
  - FSM state encodings as localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- Sub-module full_adder (a, b, cin -> sum, cout):
  - Two half_adder instances plus an OR of their carries.
  - Purely combinational, instantiated once.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: a=8'h3C, b=8'h55, cin=0, out_ready=0 for 5 cycles after out_valid -> sum=8'h91, cout=0 held stable, in_ready=0. Raising out_ready -> IDLE next edge, in_ready=1.
- Operand hold-off: new operands a=8'hAA with in_valid=1 during RUN -> ignored; the first result is unaffected, and the second operand is accepted only once the block is back in IDLE.
- Reset mid-run: pull rst_n low 3 cycles into RUN -> out_valid=0, busy=0, sum=0 immediately. After release, a=8'h01, b=8'h02 gives sum=8'h03.
- Exhaustive WIDTH=1: all 8 combinations of a, b, cin -> {cout,sum} == a+b+cin, 1-cycle RUN latency each.
